// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB slave responder.
//   - apb_state_e : responder FSM states
//   - SlvBase0..3 : byte base address of each of the four slave windows
//   - slv_base()  : window base for a slave index
//   - addr_hit()  : aligned in-window address decode
package apb_slv_pkg;

  localparam int unsigned ApbAddrW = 32;
  localparam int unsigned ApbDataW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess
  } apb_state_e;

  localparam logic [ApbAddrW-1:0] SlvBase0 = 32'h8000_0000;
  localparam logic [ApbAddrW-1:0] SlvBase1 = 32'h8400_0000;
  localparam logic [ApbAddrW-1:0] SlvBase2 = 32'h8800_0000;
  localparam logic [ApbAddrW-1:0] SlvBase3 = 32'h8C00_0000;

  function automatic logic [ApbAddrW-1:0] slv_base(input logic [1:0] idx);
    logic [ApbAddrW-1:0] base;
    unique case (idx)
      2'd0:    base = SlvBase0;
      2'd1:    base = SlvBase1;
      2'd2:    base = SlvBase2;
      default: base = SlvBase3;
    endcase
    return base;
  endfunction

  // Compare in 33 bits so a window ending at 4 GiB does not wrap.
  function automatic logic addr_hit(input logic [ApbAddrW-1:0] addr,
                                    input logic [ApbAddrW-1:0] base,
                                    input int unsigned         depth);
    logic [ApbAddrW:0] a;
    logic [ApbAddrW:0] lo;
    logic [ApbAddrW:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + {depth[30:0], 2'b00};
    return (a >= lo) && (a < hi) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/apb_slv_if.sv
// APB bus bundle between the bridge (master) and one completer (slave).
//   Pselx/Penable/Pwrite/Paddr/Pwdata : master -> slave
//   Prdata/Pready/Pslverr             : slave -> master
interface apb_slv_if;
  import apb_slv_pkg::*;

  logic [3:0]          Pselx;
  logic                Penable;
  logic                Pwrite;
  logic [ApbAddrW-1:0] Paddr;
  logic [ApbDataW-1:0] Pwdata;
  logic [ApbDataW-1:0] Prdata;
  logic                Pready;
  logic                Pslverr;

  modport master (
    output Pselx, Penable, Pwrite, Paddr, Pwdata,
    input  Prdata, Pready, Pslverr
  );

  modport slave (
    input  Pselx, Penable, Pwrite, Paddr, Pwdata,
    output Prdata, Pready, Pslverr
  );

endinterface

// File: rtl/apb_slv_mem.sv
// Depth x 32 single-port word memory.
//   clk_i   : clock
//   clr_i   : synchronous clear of every word and of the read register
//   idx_i   : word index shared by read and write
//   we_i    : write wdata_i to idx_i
//   re_i    : load the read register; rzero_i forces the loaded value to 0
//   rdata_o : registered read data, holds until the next re_i
module apb_slv_mem #(
  parameter int unsigned Depth = 256,
  localparam int unsigned IdxW = $clog2(Depth)
) (
  input  logic            clk_i,
  input  logic            clr_i,
  input  logic [IdxW-1:0] idx_i,
  input  logic            we_i,
  input  logic [31:0]     wdata_i,
  input  logic            re_i,
  input  logic            rzero_i,
  output logic [31:0]     rdata_o
);

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = rzero_i ? 32'h0 : mem_q[idx_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[idx_i] <= wdata_i;
      end
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_slave_responder.sv
// APB completer answering one Pselx line of the AHB-to-APB bridge.
//   clk, Hresetn : clock, synchronous active-low reset (also clears memory)
//   apb          : APB bus, slave side (Pselx/Penable/Pwrite/Paddr/Pwdata in,
//                  Prdata/Pready/Pslverr out, all outputs registered)
//   proto_err    : sticky protocol-violation flag, cleared only by reset
// The FSM registers the bus phase seen on the previous edge: StSetup is the
// cycle after the bus SETUP cycle, StAccess holds Pready low for WAIT_STATES
// cycles and then completes. Because outputs are registered the master always
// sees one extra low-Pready cycle before the StAccess cycles begin.
module apb_slave_responder
  import apb_slv_pkg::*;
#(
  parameter int unsigned         SLV_IDX     = 0,
  parameter logic [ApbAddrW-1:0] ADDR_BASE   = SlvBase0,
  parameter int unsigned         DEPTH       = 256,
  parameter int unsigned         WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        Hresetn,
  apb_slv_if.slave    apb,
  output logic        proto_err
);

  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam logic [1:0]  SelBit   = SLV_IDX[1:0];
  localparam logic [3:0]  WaitLoad = WAIT_STATES[3:0];

  apb_state_e          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ApbAddrW-1:0] addr_q, addr_d;
  logic                write_q, write_d;
  logic [ApbDataW-1:0] wdata_q, wdata_d;
  logic                hit_q, hit_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic                proto_err_q, proto_err_d;

  logic                sel;
  logic                same_ctl;
  logic                same_all;
  logic                start_access;
  logic                complete;
  logic                mem_we;
  logic                mem_re;
  logic                mem_rzero;
  logic [IdxW-1:0]     mem_idx;
  logic [ApbDataW-1:0] mem_rdata;

  assign sel      = apb.Pselx[SelBit];
  assign same_ctl = (apb.Paddr == addr_q) && (apb.Pwrite == write_q);
  assign same_all = same_ctl && (apb.Pwdata == wdata_q);
  assign mem_idx  = IdxW'((addr_q - ADDR_BASE) >> 2);

  // State register.
  always_ff @(posedge clk) begin
    if (!Hresetn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      hit_q       <= 1'b0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      hit_q       <= hit_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Next state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    hit_d        = hit_q;
    proto_err_d  = proto_err_q;
    start_access = 1'b0;
    complete     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sel && !apb.Penable) begin
          state_d = StSetup;
          addr_d  = apb.Paddr;
          write_d = apb.Pwrite;
          wdata_d = apb.Pwdata;
          hit_d   = addr_hit(apb.Paddr, ADDR_BASE, DEPTH);
          cnt_d   = WaitLoad;
        end else if (sel && apb.Penable) begin
          proto_err_d = 1'b1;
        end
      end
      StSetup: begin
        if (sel && apb.Penable && same_ctl) begin
          state_d      = StAccess;
          start_access = 1'b1;
        end else begin
          state_d     = StIdle;
          proto_err_d = 1'b1;
        end
      end
      StAccess: begin
        if (sel && apb.Penable && same_all) begin
          if (cnt_q == 4'd0) begin
            // Next bus SETUP lands in StIdle, so back-to-back needs no gap.
            state_d  = StIdle;
            complete = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end else begin
          state_d     = StIdle;
          proto_err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs and memory strobes.
  always_comb begin
    pready_d  = (state_d == StAccess) && (cnt_d == 4'd0);
    pslverr_d = pready_d && !hit_q;
    mem_re    = start_access;
    mem_rzero = write_q || !hit_q;
    mem_we    = complete && write_q && hit_q;
  end

  apb_slv_mem #(
    .Depth (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .clr_i   (!Hresetn),
    .idx_i   (mem_idx),
    .we_i    (mem_we),
    .wdata_i (wdata_q),
    .re_i    (mem_re),
    .rzero_i (mem_rzero),
    .rdata_o (mem_rdata)
  );

  assign apb.Prdata  = mem_rdata;
  assign apb.Pready  = pready_q;
  assign apb.Pslverr = pslverr_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_apb_slave_responder.sv
// Three responders (SLV_IDX=0, DEPTH=256) with WAIT_STATES 0, 2 and 3, each on
// its own bus and reset. A transaction-level model predicts every output each
// cycle; a negedge process compares, and directed literals pin the model.
module tb_apb_slave_responder;

  localparam int          NDut = 3;
  localparam logic [31:0] Base = 32'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn   [NDut];
  logic [3:0]  psel   [NDut];
  logic        pen    [NDut];
  logic        pwr    [NDut];
  logic [31:0] paddr  [NDut];
  logic [31:0] pwdata [NDut];
  logic [31:0] prdata [NDut];
  logic        pready [NDut];
  logic        pslverr[NDut];
  logic        perr   [NDut];

  logic [31:0] e_prdata [NDut];
  logic        e_pready [NDut];
  logic        e_pslverr[NDut];
  logic        e_perr   [NDut];
  logic [31:0] mmem     [NDut][256];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    apb_slv_if bus ();
    assign bus.Pselx   = psel[g];
    assign bus.Penable = pen[g];
    assign bus.Pwrite  = pwr[g];
    assign bus.Paddr   = paddr[g];
    assign bus.Pwdata  = pwdata[g];
    assign prdata[g]   = bus.Prdata;
    assign pready[g]   = bus.Pready;
    assign pslverr[g]  = bus.Pslverr;

    apb_slave_responder #(
      .SLV_IDX     (0),
      .ADDR_BASE   (Base),
      .DEPTH       (256),
      .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
    ) u_dut (
      .clk       (clk),
      .Hresetn   (rstn[g]),
      .apb       (bus),
      .proto_err (perr[g])
    );
  end

  function automatic int wait_of(input int g);
    return (g == 0) ? 0 : ((g == 1) ? 2 : 3);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return (a >= Base) && (a < Base + 32'd1024) && (a[1:0] == 2'b00);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'(((a - Base) >> 2) & 32'hFF);
  endfunction

  task automatic chk(input string name, input int g, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s u%0d got %h want %h at %0t", name, g, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < NDut; g++) begin
        chk("Pready", g, 32'(pready[g]), 32'(e_pready[g]));
        chk("Pslverr", g, 32'(pslverr[g]), 32'(e_pslverr[g]));
        chk("Prdata", g, prdata[g], e_prdata[g]);
        chk("proto_err", g, 32'(perr[g]), 32'(e_perr[g]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int g);
    psel[g] = 4'b0;
    pen[g]  = 1'b0;
    cyc();
  endtask

  task automatic model_reset(input int g);
    e_prdata[g]  = '0;
    e_pready[g]  = 1'b0;
    e_pslverr[g] = 1'b0;
    e_perr[g]    = 1'b0;
    for (int i = 0; i < 256; i++) mmem[g][i] = '0;
  endtask

  // One APB transfer; leaves the bus driven so a following xfer is back-to-back.
  task automatic xfer(input int g, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] selv,
                      output logic [31:0] rd, output logic err, output int lows);
    bit resp;
    bit hit;
    int idx;
    int w;
    resp = selv[0];
    hit  = m_hit(addr);
    idx  = m_idx(addr);
    w    = wait_of(g);
    rd   = '0;
    err  = 1'b0;
    lows = 0;
    psel[g] = selv; pen[g] = 1'b0; pwr[g] = wr; paddr[g] = addr; pwdata[g] = wd;
    cyc();
    e_pready[g] = 1'b0; e_pslverr[g] = 1'b0;
    pen[g] = 1'b1;
    for (int k = 0; k <= w + 2; k++) begin
      cyc();
      if (resp) begin
        if (k == 0) e_prdata[g] = (wr || !hit) ? 32'h0 : mmem[g][idx];
        e_pready[g]  = (k == w);
        e_pslverr[g] = (k == w) && !hit;
        if (pready[g] !== 1'b1) lows++;
        if (k == w) begin
          rd  = prdata[g];
          err = pslverr[g];
          break;
        end
      end
    end
    cyc();
    if (resp && wr && hit) mmem[g][idx] = wd;
    e_pready[g] = 1'b0; e_pslverr[g] = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          lows;

  initial begin
    for (int g = 0; g < NDut; g++) begin
      rstn[g] = 1'b0; psel[g] = 4'b0; pen[g] = 1'b0; pwr[g] = 1'b0;
      paddr[g] = '0; pwdata[g] = '0;
      model_reset(g);
    end
    cyc();
    cyc();
    chk_en = 1'b1;
    chk("rst_prdata", 0, prdata[0], 32'h0);
    chk("rst_pready", 2, 32'(pready[2]), 32'h0);
    for (int g = 0; g < NDut; g++) rstn[g] = 1'b1;
    cyc();

    // WAIT_STATES=0: write then read back.
    xfer(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b0001, rd, err, lows);
    idle(0);
    chk("wr_err", 0, 32'(err), 32'h0);
    chk("wr_lows", 0, 32'(lows), 32'h0);
    xfer(0, 1'b0, 32'h8000_0010, 32'h0, 4'b0001, rd, err, lows);
    idle(0);
    chk("rd_data", 0, rd, 32'hDEAD_BEEF);
    chk("rd_err", 0, 32'(err), 32'h0);

    // Out of range read and misaligned write both error.
    xfer(0, 1'b0, 32'h8000_0400, 32'h0, 4'b0001, rd, err, lows);
    idle(0);
    chk("oor_err", 0, 32'(err), 32'h1);
    chk("oor_data", 0, rd, 32'h0);
    xfer(0, 1'b1, 32'h8000_0002, 32'h5555_AAAA, 4'b0001, rd, err, lows);
    idle(0);
    chk("mis_err", 0, 32'(err), 32'h1);
    xfer(0, 1'b0, 32'h8000_0000, 32'h0, 4'b0001, rd, err, lows);
    idle(0);
    chk("mis_nowr", 0, rd, 32'h0);

    // Other select bit: ignored.
    xfer(0, 1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'b0010, rd, err, lows);
    idle(0);
    xfer(0, 1'b0, 32'h8000_0000, 32'h0, 4'b0001, rd, err, lows);
    idle(0);
    chk("nosel_mem", 0, rd, 32'h0);
    chk("nosel_perr", 0, 32'(perr[0]), 32'h0);

    // Back-to-back write then read.
    xfer(0, 1'b1, 32'h8000_0004, 32'h1111_2222, 4'b0001, rd, err, lows);
    xfer(0, 1'b0, 32'h8000_0004, 32'h0, 4'b0001, rd, err, lows);
    idle(0);
    chk("b2b_data", 0, rd, 32'h1111_2222);

    // WAIT_STATES=2: read after reset.
    xfer(1, 1'b0, 32'h8000_0000, 32'h0, 4'b0001, rd, err, lows);
    idle(1);
    chk("w2_lows", 1, 32'(lows), 32'h2);
    chk("w2_data", 1, rd, 32'h0);

    // Penable without a SETUP phase.
    psel[1] = 4'b0001; pen[1] = 1'b1; pwr[1] = 1'b1;
    paddr[1] = 32'h8000_0008; pwdata[1] = 32'hBAD0_BAD0;
    cyc();
    e_perr[1] = 1'b1;
    idle(1);
    chk("nosetup_perr", 1, 32'(perr[1]), 32'h1);
    xfer(1, 1'b1, 32'h8000_000C, 32'hA5A5_A5A5, 4'b0001, rd, err, lows);
    xfer(1, 1'b0, 32'h8000_000C, 32'h0, 4'b0001, rd, err, lows);
    idle(1);
    chk("w2_wr_rd", 1, rd, 32'hA5A5_A5A5);
    xfer(1, 1'b0, 32'h8000_0008, 32'h0, 4'b0001, rd, err, lows);
    idle(1);
    chk("nosetup_nowr", 1, rd, 32'h0);
    chk("perr_sticky", 1, 32'(perr[1]), 32'h1);

    // WAIT_STATES=3: Paddr changes mid-ACCESS.
    psel[2] = 4'b0001; pen[2] = 1'b0; pwr[2] = 1'b1;
    paddr[2] = 32'h8000_0040; pwdata[2] = 32'h1234_5678;
    cyc();
    pen[2] = 1'b1;
    cyc();
    e_prdata[2] = 32'h0;
    paddr[2] = 32'h8000_0044;
    cyc();
    e_perr[2] = 1'b1;
    idle(2);
    chk("chg_perr", 2, 32'(perr[2]), 32'h1);
    xfer(2, 1'b0, 32'h8000_0040, 32'h0, 4'b0001, rd, err, lows);
    idle(2);
    chk("chg_nowr40", 2, rd, 32'h0);
    xfer(2, 1'b0, 32'h8000_0044, 32'h0, 4'b0001, rd, err, lows);
    idle(2);
    chk("chg_nowr44", 2, rd, 32'h0);

    // Reset clears the sticky flag.
    rstn[2] = 1'b0;
    cyc();
    model_reset(2);
    rstn[2] = 1'b1;
    cyc();
    chk("rst_clr_perr", 2, 32'(perr[2]), 32'h0);

    // Reset in the middle of a write's ACCESS phase.
    xfer(2, 1'b1, 32'h8000_0030, 32'h0000_0077, 4'b0001, rd, err, lows);
    xfer(2, 1'b0, 32'h8000_0030, 32'h0, 4'b0001, rd, err, lows);
    idle(2);
    chk("w3_lows", 2, 32'(lows), 32'h3);
    chk("w3_data", 2, rd, 32'h0000_0077);
    psel[2] = 4'b0001; pen[2] = 1'b0; pwr[2] = 1'b1;
    paddr[2] = 32'h8000_0020; pwdata[2] = 32'h0BAD_F00D;
    cyc();
    pen[2] = 1'b1;
    cyc();
    e_prdata[2] = 32'h0;
    cyc();
    rstn[2] = 1'b0;
    cyc();
    model_reset(2);
    chk("mid_rst_pready", 2, 32'(pready[2]), 32'h0);
    chk("mid_rst_perr", 2, 32'(perr[2]), 32'h0);
    psel[2] = 4'b0; pen[2] = 1'b0; rstn[2] = 1'b1;
    cyc();
    xfer(2, 1'b0, 32'h8000_0020, 32'h0, 4'b0001, rd, err, lows);
    idle(2);
    chk("mid_rst_nowr", 2, rd, 32'h0);
    xfer(2, 1'b0, 32'h8000_0030, 32'h0, 4'b0001, rd, err, lows);
    idle(2);
    chk("mid_rst_clr", 2, rd, 32'h0);

    cyc();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
